// File: rtl/fir_data_ctrl_if.sv
// rtl/fir_data_ctrl_if.sv - sample stream, data RAM and MAC feed signals of the FIR data controller
interface fir_data_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              clr;
  logic              ss_tvalid;
  logic [DATA_W-1:0] ss_tdata;
  logic              ss_tlast;
  logic              ss_tready;
  logic [3:0]        bram_WE;
  logic              bram_EN;
  logic [DATA_W-1:0] bram_Di;
  logic [ADDR_W-1:0] bram_A;
  logic [DATA_W-1:0] bram_Do;
  logic              x_valid;
  logic [DATA_W-1:0] x_data;
  logic [3:0]        tap_idx;
  logic              x_last;
  logic              x_tlast;
  logic              idle;

  // Controller side
  modport master (
    input  clr, ss_tvalid, ss_tdata, ss_tlast, bram_Do,
    output ss_tready, bram_WE, bram_EN, bram_Di, bram_A,
           x_valid, x_data, tap_idx, x_last, x_tlast, idle
  );

  // Environment side: sample source, data RAM and MAC
  modport slave (
    output clr, ss_tvalid, ss_tdata, ss_tlast, bram_Do,
    input  ss_tready, bram_WE, bram_EN, bram_Di, bram_A,
           x_valid, x_data, tap_idx, x_last, x_tlast, idle
  );
endinterface

// File: rtl/fir_data_ctrl.sv
// rtl/fir_data_ctrl.sv - FIR sample delay-line controller over a circular data RAM
module fir_data_ctrl #(
  parameter int TAPS   = 11,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input logic            clk,
  input logic            rst,
  fir_data_ctrl_if.master bus
);
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] init_cnt;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] tap_cnt;
  logic [CW-1:0] tap_q;
  logic          tlast_q;
  logic          xv_q;
  logic          xl_q;
  logic          xt_q;
  logic          accept;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CW-1:0] w);
    return ADDR_W'({w, 2'b00});
  endfunction

  // clr has priority over a pending sample in IDLE
  assign accept = (state == S_IDLE) && bus.ss_tvalid && !bus.clr;

  // RAM port and handshake decode; everything is held quiet while reset is high
  always_comb begin
    bus.ss_tready = 1'b0;
    bus.bram_EN   = 1'b0;
    bus.bram_WE   = 4'h0;
    bus.bram_A    = '0;
    bus.bram_Di   = '0;
    bus.idle      = 1'b0;
    if (!rst) begin
      case (state)
        S_INIT: begin
          bus.bram_EN = 1'b1;
          bus.bram_WE = 4'hF;
          bus.bram_A  = word_addr(init_cnt);
        end
        S_IDLE: begin
          bus.ss_tready = 1'b1;
          bus.idle      = 1'b1;
          if (accept) begin
            bus.bram_EN = 1'b1;
            bus.bram_WE = 4'hF;
            bus.bram_A  = word_addr(wr_ptr);
            bus.bram_Di = bus.ss_tdata;
          end
        end
        S_READ: begin
          bus.bram_EN = 1'b1;
          bus.bram_A  = word_addr(rd_ptr);
        end
        S_DRAIN: begin
          bus.bram_EN = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State machine, circular write pointer and newest-to-oldest read walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tap_cnt  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == LAST) begin
            init_cnt <= '0;
            wr_ptr   <= '0;
            state    <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (bus.clr) begin
            init_cnt <= '0;
            state    <= S_INIT;
          end else if (bus.ss_tvalid) begin
            rd_ptr  <= wr_ptr;
            tap_cnt <= '0;
            tlast_q <= bus.ss_tlast;
            wr_ptr  <= (wr_ptr == LAST) ? '0 : wr_ptr + CW'(1);
            state   <= S_READ;
          end
        end
        S_READ: begin
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - CW'(1);
          if (tap_cnt == LAST) begin
            state <= S_DRAIN;
          end else begin
            tap_cnt <= tap_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Tap qualifiers follow the read address by one cycle to line up with bram_Do
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xv_q  <= 1'b0;
      xl_q  <= 1'b0;
      xt_q  <= 1'b0;
      tap_q <= '0;
    end else begin
      xv_q <= (state == S_READ);
      xl_q <= (state == S_READ) && (tap_cnt == LAST);
      xt_q <= (state == S_READ) && (tap_cnt == LAST) && tlast_q;
      if (state == S_READ) begin
        tap_q <= tap_cnt;
      end
    end
  end

  assign bus.x_valid = xv_q;
  assign bus.x_last  = xl_q;
  assign bus.x_tlast = xt_q;
  assign bus.tap_idx = tap_q;
  assign bus.x_data  = xv_q ? bus.bram_Do : '0;
endmodule
